// File: rtl/mul_reg_sequencer.sv
// mul_reg_sequencer: expands Thumb PUSH/POP/STM/LDM into single-register memory micro-ops plus base writeback.
module mul_reg_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  instr_valid_i,
  input  logic [15:0]           instruction_i,
  output logic                  instr_ready_o,
  input  logic                  flush_i,
  output logic                  uop_valid_o,
  input  logic                  uop_ready_i,
  output logic [1:0]            uop_kind_o,
  output logic [ADDR_WIDTH-1:0] uop_base_reg_o,
  output logic [ADDR_WIDTH-1:0] uop_data_reg_o,
  output logic [7:0]            uop_offset_o,
  output logic                  uop_last_o,
  output logic                  busy_o
);
  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;
  state_t state_q, state_d;
  logic [15:0] list_q, list_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic push_q, push_d, load_q, load_d, wb_q, wb_d;
  logic [3:0] cnt_q, cnt_d, k_q, k_d;
  logic is_push, is_pop, is_stm, is_ldm, known, dec_wb;
  logic [15:0] dec_list, rest;
  logic [3:0] dec_cnt, lo;
  logic [ADDR_WIDTH-1:0] dec_base;
  logic [7:0] off_k, off_n, mem_off, wb_off;
  assign is_push  = instruction_i[15:9] == 7'b1011010;
  assign is_pop   = instruction_i[15:9] == 7'b1011110;
  assign is_stm   = instruction_i[15:11] == 5'b11000;
  assign is_ldm   = instruction_i[15:11] == 5'b11001;
  assign known    = is_push | is_pop | is_stm | is_ldm;
  assign dec_list = {is_pop & instruction_i[8], is_push & instruction_i[8], 6'b0,
                     known ? instruction_i[7:0] : 8'h00};
  assign dec_base = (is_push | is_pop) ? ADDR_WIDTH'(13) : ADDR_WIDTH'(instruction_i[10:8]);
  // LDM with the base in its own list leaves the loaded value, not the written-back one
  assign dec_wb   = !is_ldm || !dec_list[instruction_i[10:8]];
  always_comb begin
    dec_cnt = '0;
    for (int i = 0; i < 16; i++) dec_cnt = dec_cnt + 4'(dec_list[i]);
  end
  always_comb begin
    lo = '0;
    for (int i = 15; i >= 0; i--) if (list_q[i]) lo = 4'(i);
  end
  assign rest    = list_q & (list_q - 16'd1);
  assign off_k   = 8'(k_q * WORD_BYTES);
  assign off_n   = 8'(cnt_q * WORD_BYTES);
  assign mem_off = push_q ? off_k - off_n : off_k;
  assign wb_off  = push_q ? 8'd0 - off_n : off_n;
  assign uop_valid_o    = state_q != IDLE;
  assign busy_o         = state_q != IDLE;
  assign instr_ready_o  = state_q == IDLE;
  assign uop_kind_o     = state_q == WB ? 2'd2 : state_q == XFER ? {1'b0, !load_q} : 2'd0;
  assign uop_base_reg_o = uop_valid_o ? base_q : '0;
  assign uop_data_reg_o = state_q == WB ? base_q : state_q == XFER ? ADDR_WIDTH'(lo) : '0;
  assign uop_offset_o   = state_q == WB ? wb_off : state_q == XFER ? mem_off : 8'd0;
  assign uop_last_o     = state_q == WB || (state_q == XFER && rest == 16'd0 && !wb_q);
  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    base_d  = base_q;
    push_d  = push_q;
    load_d  = load_q;
    wb_d    = wb_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    if (flush_i) state_d = IDLE;
    else if (state_q == IDLE && instr_valid_i && dec_cnt != 4'd0) begin
      state_d = XFER;
      list_d  = dec_list;
      base_d  = dec_base;
      push_d  = is_push;
      load_d  = is_ldm | is_pop;
      wb_d    = dec_wb;
      cnt_d   = dec_cnt;
      k_d     = '0;
    end else if (state_q == XFER && uop_ready_i) begin
      list_d = rest;
      k_d    = k_q + 4'd1;
      if (rest == 16'd0) state_d = wb_q ? WB : IDLE;
    end else if (state_q == WB && uop_ready_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      list_q  <= '0;
      base_q  <= '0;
      push_q  <= 1'b0;
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      base_q  <= base_d;
      push_q  <= push_d;
      load_q  <= load_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end
endmodule

// File: tb/tb_mul_reg_sequencer.sv
// tb_mul_reg_sequencer: queue-based model of the register-list expansion plus literal pins on observed transfers.
module tb_mul_reg_sequencer;
  logic clk_i = 1'b0, rst_n_i = 1'b0, instr_valid_i = 1'b0, flush_i = 1'b0, uop_ready_i = 1'b1;
  logic [15:0] instruction_i = 16'h0;
  logic instr_ready_o, uop_valid_o, uop_last_o, busy_o;
  logic [1:0] uop_kind_o;
  logic [3:0] uop_base_reg_o, uop_data_reg_o;
  logic [7:0] uop_offset_o;
  int tests = 0, errors = 0;
  bit en = 0;
  typedef struct {int kind; int base; int data; int off; int last;} uop_t;
  uop_t q[$], obs[$], lit[$];

  mul_reg_sequencer #(.ADDR_WIDTH(4), .WORD_BYTES(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_valid_i(instr_valid_i), .instruction_i(instruction_i),
    .instr_ready_o(instr_ready_o), .flush_i(flush_i), .uop_valid_o(uop_valid_o), .uop_ready_i(uop_ready_i),
    .uop_kind_o(uop_kind_o), .uop_base_reg_o(uop_base_reg_o), .uop_data_reg_o(uop_data_reg_o),
    .uop_offset_o(uop_offset_o), .uop_last_o(uop_last_o), .busy_o(busy_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expand(input logic [15:0] ins);
    bit push, pop, stm, ldm, wb;
    logic [15:0] lst;
    int base, n, k;
    push = ins[15:9] == 7'b1011010;
    pop  = ins[15:9] == 7'b1011110;
    stm  = ins[15:11] == 5'b11000;
    ldm  = ins[15:11] == 5'b11001;
    if (!(push || pop || stm || ldm)) return;
    lst = {8'h00, ins[7:0]};
    if (push && ins[8]) lst[14] = 1'b1;
    if (pop && ins[8]) lst[15] = 1'b1;
    base = (push || pop) ? 13 : int'(ins[10:8]);
    n = 0;
    for (int r = 0; r < 16; r++) n += int'(lst[r]);
    if (n == 0) return;
    wb = !ldm || !lst[base];
    k = 0;
    for (int r = 0; r < 16; r++)
      if (lst[r]) begin
        q.push_back('{(ldm || pop) ? 0 : 1, base, r, push ? 4*k - 4*n : 4*k, (k == n-1 && !wb) ? 1 : 0});
        k++;
      end
    if (wb) q.push_back('{2, base, base, push ? -4*n : 4*n, 1});
  endtask

  always @(posedge clk_i) begin
    if (rst_n_i && !flush_i && uop_valid_o && uop_ready_i)
      obs.push_back('{int'(uop_kind_o), int'(uop_base_reg_o), int'(uop_data_reg_o),
                      int'($signed(uop_offset_o)), int'(uop_last_o)});
    if (!rst_n_i || flush_i) q.delete();
    else if (q.size() > 0) begin
      if (uop_ready_i) void'(q.pop_front());
    end else if (instr_valid_i) expand(instruction_i);
  end

  always @(negedge clk_i) if (en) begin
    chk("valid", int'(uop_valid_o), int'(q.size() > 0));
    chk("busy", int'(busy_o), int'(q.size() > 0));
    chk("instr_ready", int'(instr_ready_o), int'(q.size() == 0));
    if (uop_valid_o && q.size() > 0) begin
      chk("kind", int'(uop_kind_o), q[0].kind);
      chk("base", int'(uop_base_reg_o), q[0].base);
      chk("data", int'(uop_data_reg_o), q[0].data);
      chk("offset", int'($signed(uop_offset_o)), q[0].off);
      chk("last", int'(uop_last_o), q[0].last);
    end
  end

  task automatic pin(input int kind, input int base, input int data, input int off, input int last);
    lit.push_back('{kind, base, data, off, last});
  endtask

  task automatic chk_log(input string name);
    chk({name, "_count"}, obs.size(), lit.size());
    for (int i = 0; i < lit.size() && i < obs.size(); i++) begin
      chk($sformatf("%s_%0d_kind", name, i), obs[i].kind, lit[i].kind);
      chk($sformatf("%s_%0d_data", name, i), obs[i].data, lit[i].data);
      chk($sformatf("%s_%0d_base", name, i), obs[i].base, lit[i].base);
      chk($sformatf("%s_%0d_off", name, i), obs[i].off, lit[i].off);
      chk($sformatf("%s_%0d_last", name, i), obs[i].last, lit[i].last);
    end
    obs.delete();
    lit.delete();
  endtask

  task automatic issue(input logic [15:0] ins);
    instruction_i = ins;
    instr_valid_i = 1'b1;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input bit toggle, output int n);
    n = 0;
    while (busy_o && n < 100) begin
      @(posedge clk_i); #1;
      if (toggle) uop_ready_i = !uop_ready_i;
      n++;
    end
    uop_ready_i = 1'b1;
    chk("idle_timeout", int'(busy_o), 0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, int'(uop_valid_o), 0);
    chk({name, "_busy"}, int'(busy_o), 0);
    chk({name, "_last"}, int'(uop_last_o), 0);
    chk({name, "_fields"}, int'({uop_kind_o, uop_base_reg_o, uop_data_reg_o, uop_offset_o}), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk_i);
    #1;
    en = 1;
    chk_zero("reset");
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("reset_ready", int'(instr_ready_o), 1);
    issue(16'hB505);
    wait_idle(0, n);
    chk("push_busy_cycles", n, 4);
    chk("push_ready_after", int'(instr_ready_o), 1);
    pin(1, 13, 0, -12, 0); pin(1, 13, 2, -8, 0); pin(1, 13, 14, -4, 0); pin(2, 13, 13, -12, 1);
    chk_log("push");
    issue(16'hBD02);
    wait_idle(0, n);
    pin(0, 13, 1, 0, 0); pin(0, 13, 15, 4, 0); pin(2, 13, 13, 8, 1);
    chk_log("pop");
    issue(16'hCB09);
    wait_idle(0, n);
    pin(0, 3, 0, 0, 0); pin(0, 3, 3, 4, 1);
    chk_log("ldm");
    issue(16'hC1FF);
    wait_idle(1, n);
    for (int i = 0; i < 8; i++) pin(1, 1, i, 4*i, 0);
    pin(2, 1, 1, 32, 1);
    chk_log("stm");
    issue(16'hC1FF);
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_valid", int'(uop_valid_o), 0);
    chk("flush_busy", int'(busy_o), 0);
    chk("flush_ready", int'(instr_ready_o), 1);
    pin(1, 1, 0, 0, 0);
    chk_log("flush");
    instruction_i = 16'hB505;
    instr_valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_idle_block", int'(busy_o), 0);
    issue(16'hC1FF);
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    chk_zero("midreset");
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("midreset_ready", int'(instr_ready_o), 1);
    obs.delete();
    issue(16'hB400);
    chk("empty_push_busy", int'(busy_o), 0);
    issue(16'h1C48);
    chk("add_busy", int'(busy_o), 0);
    repeat (2) @(posedge clk_i); #1;
    chk("noop_ready", int'(instr_ready_o), 1);
    chk_log("noop");
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/mul_reg_sequencer.md
Name: mul_reg_sequencer

Overview:
- Sequencer for Thumb multiple-register transfers: PUSH, POP, STM and LDM (writeback forms).
- Sits between decode and the register-address/memory pipeline. It accepts one multi-register instruction and expands its register list into one single-register memory micro-op per listed register, plus an optional base-writeback micro-op.
- Holds decode off (busy_o) until the expansion completes, so downstream logic only ever sees single-register transfers.

Parameters:
- ADDR_WIDTH, 4: register address width (r0-r15; SP = 13, LR = 14, PC = 15).
- WORD_BYTES, 4: byte stride between consecutive transfers.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  reset, synchronous, active-low
- instr_valid_i  input  1  instruction_i valid
- instruction_i  input  16  Thumb instruction from decode
- instr_ready_o  output  1  block can accept; equals (state == IDLE)
- flush_i  input  1  pipeline flush; aborts the sequence
- uop_valid_o  output  1  micro-op valid
- uop_ready_i  input  1  downstream accepts micro-op
- uop_kind_o  output  2  0 = LOAD, 1 = STORE, 2 = BASE_WB
- uop_base_reg_o  output  ADDR_WIDTH  address base register
- uop_data_reg_o  output  ADDR_WIDTH  LOAD dest / STORE source / BASE_WB dest (the base)
- uop_offset_o  output  8  signed two's-complement byte offset from the base
- uop_last_o  output  1  final micro-op of the instruction
- busy_o  output  1  sequence in progress; stalls fetch/decode

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - state = IDLE; uop_valid_o, uop_last_o, busy_o = 0; all uop fields = 0; instr_ready_o = 1 once out of reset.
  - Reset mid-sequence discards it; no further micro-ops are issued.
- Recognised instructions:
  - PUSH: 1011_010_M_list. Base 13. List bit 14 = M.
  - POP: 1011_110_P_list. Base 13. List bit 15 = P.
  - STM: 11000_Rn_list. Base = Rn.
  - LDM: 11001_Rn_list. Base = Rn.
  - The list is 16 bits internally; count = popcount (0..9).
- Other instructions, and a recognised instruction with count == 0: the handshake completes, nothing is issued, state stays IDLE.
- States:
  - IDLE: on instr_valid_i && instr_ready_o with a recognised, non-empty list, register the remaining list, base, kind, count and k = 0, then go to XFER. The first micro-op is valid on the next cycle (latency 1).
  - XFER: present a micro-op for the lowest set bit of the remaining list. On uop_valid_o && uop_ready_i:
    - clear that bit; k++;
    - when it was the last bit, go to WB if writeback applies, else IDLE.
  - WB: present BASE_WB. On handshake, go to IDLE.
- Offsets (8-bit signed):
  - STM/LDM/POP: offset = 4*k.
  - PUSH: offset = 4*k - 4*count (full descending; lowest register at the lowest address).
  - BASE_WB offset: +4*count for STM/LDM/POP, -4*count for PUSH.
- Writeback applies to PUSH, POP and STM always, and to LDM only when Rn is not in the list.
- uop_last_o is set on BASE_WB, or on the final memory micro-op when there is no writeback.
- Micro-op fields are registered and held stable while uop_valid_o && !uop_ready_i.
- busy_o = (state != IDLE). A new instruction is accepted no earlier than the cycle after the last handshake.
- flush_i:
  - Highest priority after reset: next cycle state = IDLE and uop_valid_o = 0.
  - A uop_ready_i in the same cycle as flush_i does not count as a transfer.
  - flush_i in IDLE also blocks acceptance that cycle.
- Registers r8-r12 can never appear in the list; PC appears only via POP P.

Test Plan:
- PUSH {r0,r2,LR} (0xB505) with uop_ready_i = 1 → STORE r0 base 13 off -12; STORE r2 off -8; STORE r14 off -4; BASE_WB r13 off -12 with last = 1. busy_o high for 4 cycles; instr_ready_o high on the 5th.
- POP {r1,PC} (0xBD02) → LOAD r1 off 0; LOAD r15 off 4; BASE_WB r13 off +8 with last.
- LDM r3!,{r0,r3} (0xCB09) → LOAD r0 base 3 off 0; LOAD r3 off 4 with last = 1; no BASE_WB.
- STM r1!,{r0-r7} (0xC1FF) with uop_ready_i toggling 1/0 → 8 STOREs at off 0,4,...,28, each field held while ready = 0; BASE_WB r1 off +32 with last.
- Abort and reset: flush_i asserted during the 2nd STORE of 0xC1FF → uop_valid_o = 0 next cycle, state IDLE, instr_ready_o = 1. rst_n_i low mid-sequence → all outputs 0, busy_o = 0.
- No-op inputs: empty PUSH (0xB400) and ADD (0x1C48) → handshake completes, uop_valid_o stays 0, busy_o stays 0.
